// File: rtl/led_bank_sequencer.sv
// led_bank_sequencer: drives one-cycle enable/data strobes into a reset-less LED bank.
// It keeps a shadow of the bank contents and clears the bank after reset.
module led_bank_sequencer #(
   parameter int NUM_LEDS = 8,
   parameter int PRESCALE = 4,
   parameter int STEP_W   = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [1:0]          cmd_op_i,
   input  logic [NUM_LEDS-1:0] cmd_data_i,
   input  logic                abort_i,
   output logic [NUM_LEDS-1:0] en_o,
   output logic [NUM_LEDS-1:0] d_o,
   output logic [NUM_LEDS-1:0] pattern_o,
   output logic                busy_o,
   output logic                done_o
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   typedef enum logic [1:0] {INIT, IDLE, RUN} state_t;
   state_t              state_q;
   logic [NUM_LEDS-1:0] en_q, d_q, pat_q;
   logic                ready_q, busy_q, done_q;
   logic [STEP_W-1:0]   step_q;
   logic [PW-1:0]       pre_q;
   logic [NUM_LEDS-1:0] rot_d;
   logic [STEP_W-1:0]   steps_d;
   assign rot_d   = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
   assign steps_d = cmd_data_i[STEP_W-1:0];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= INIT;
         en_q    <= '0;
         d_q     <= '0;
         pat_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         step_q  <= '0;
         pre_q   <= '0;
      end else begin
         en_q   <= '0;
         d_q    <= '0;
         done_q <= 1'b0;
         case (state_q)
            INIT: begin
               en_q    <= '1;
               pat_q   <= '0;
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            IDLE: if (cmd_valid_i && ready_q) begin
               case (cmd_op_i)
                  2'd0: begin
                     en_q  <= '1;
                     d_q   <= cmd_data_i;
                     pat_q <= cmd_data_i;
                  end
                  2'd1: begin
                     en_q  <= cmd_data_i;
                     d_q   <= cmd_data_i;
                     pat_q <= pat_q | cmd_data_i;
                  end
                  2'd2: begin
                     en_q  <= cmd_data_i;
                     pat_q <= pat_q & ~cmd_data_i;
                  end
                  default: if (steps_d == '0) done_q <= 1'b1;
                  else begin
                     step_q  <= steps_d;
                     pre_q   <= PRE_MAX;
                     state_q <= RUN;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               endcase
            end
            RUN: if (abort_i) begin
               // abort wins over a step due on the same edge
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else if (pre_q != '0) pre_q <= pre_q - PW'(1);
            else begin
               en_q   <= '1;
               d_q    <= rot_d;
               pat_q  <= rot_d;
               pre_q  <= PRE_MAX;
               step_q <= step_q - STEP_W'(1);
               if (step_q == STEP_W'(1)) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end
   assign cmd_ready_o = ready_q;
   assign en_o        = en_q;
   assign d_o         = d_q;
   assign pattern_o   = pat_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
endmodule

// File: tb/tb_led_bank_sequencer.sv
// tb_led_bank_sequencer: directed commands push hand-computed strobe/done events;
// a negedge monitor pops and compares each event the DUT presents, including its cycle.
module tb_led_bank_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic       ready;
   logic [1:0] op = '0;
   logic [7:0] data = '0;
   logic       abort = 1'b0;
   logic [7:0] en, d, pat;
   logic       busy, done;
   int         cyc = 0;
   int         n_pass = 0;
   int         n_tot = 0;

   typedef struct {
      int         c;
      logic [7:0] en;
      logic [7:0] d;
      logic [7:0] pat;
      logic       done;
   } ev_t;
   ev_t q[$];

   led_bank_sequencer #(.NUM_LEDS(8), .PRESCALE(4), .STEP_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(valid), .cmd_ready_o(ready),
      .cmd_op_i(op), .cmd_data_i(data), .abort_i(abort),
      .en_o(en), .d_o(d), .pattern_o(pat), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_tot++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input int c, input logic [7:0] e, input logic [7:0] dd,
                       input logic [7:0] p, input logic dn);
      ev_t ev;
      ev.c = c; ev.en = e; ev.d = dd; ev.pat = p; ev.done = dn;
      q.push_back(ev);
   endtask

   task automatic send(input logic [1:0] o, input logic [7:0] v);
      valid = 1'b1; op = o; data = v;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(!busy, "wait_idle", busy, 0);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // monitor: any strobe, stray data or done pulse must match the next queued event
   always @(negedge clk) begin
      if (en != 0 || d != 0 || done) begin
         if (q.size() == 0) chk(0, "unexpected_output", {7'd0, done, en, d, pat}, 0);
         else begin
            ev_t ev;
            ev = q.pop_front();
            chk(cyc == ev.c, "event_cycle", cyc, ev.c);
            chk({en, d, pat, done} == {ev.en, ev.d, ev.pat, ev.done}, "event_value",
                {7'd0, done, en, d, pat}, {7'd0, ev.done, ev.en, ev.d, ev.pat});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a;
      repeat (2) @(negedge clk);
      // reset release: cycle 1 shows reset values, next edge registers the init clear
      rst = 1'b0;
      chk(en == 0 && ready == 0 && busy == 1 && pat == 0 && done == 0, "reset_state",
          {en, 7'd0, ready, 7'd0, busy, pat}, 32'h0000_0100);
      push(cyc + 1, 8'hFF, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk(en == 0 && ready == 1 && busy == 0 && pat == 0, "idle_after_init",
          {en, 7'd0, ready, 7'd0, busy, pat}, 32'h0001_0000);
      // back-to-back WRITE / SET / CLEAR
      push(cyc + 1, 8'hFF, 8'hA5, 8'hA5, 1'b0);
      push(cyc + 2, 8'h0F, 8'h0F, 8'hAF, 1'b0);
      push(cyc + 3, 8'h81, 8'h00, 8'h2E, 1'b0);
      send(2'd0, 8'hA5);
      send(2'd1, 8'h0F);
      send(2'd2, 8'h81);
      repeat (2) @(negedge clk);
      chk(pat == 8'h2E, "b2b_pattern", pat, 8'h2E);
      // rotate with three steps
      push(cyc + 1, 8'hFF, 8'h81, 8'h81, 1'b0);
      send(2'd0, 8'h81);
      a = cyc + 1;
      push(a + 4, 8'hFF, 8'h03, 8'h03, 1'b0);
      push(a + 8, 8'hFF, 8'h06, 8'h06, 1'b0);
      push(a + 12, 8'hFF, 8'h0C, 8'h0C, 1'b1);
      send(2'd3, 8'd3);
      chk(ready == 0 && busy == 1, "run_flags", {ready, busy}, 2'b01);
      // commands offered while running must be ignored
      send(2'd0, 8'hFF);
      wait_idle();
      chk(ready == 1 && pat == 8'h0C, "rotate_end", {ready, pat}, 9'h10C);
      // rotate with zero steps: done only, still ready
      push(cyc + 1, 8'h00, 8'h00, 8'h0C, 1'b0 | 1'b1);
      send(2'd3, 8'd0);
      chk(ready == 1 && busy == 0, "rot0_ready", {ready, busy}, 2'b10);
      @(negedge clk);
      chk(done == 0, "rot0_done_one_cycle", done, 0);
      // abort in IDLE does nothing
      abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
      chk(busy == 0 && pat == 8'h0C, "abort_idle_ignored", {busy, pat}, 9'h00C);
      // abort on the edge of step 2
      a = cyc + 1;
      push(a + 4, 8'hFF, 8'h18, 8'h18, 1'b0);
      push(a + 8, 8'h00, 8'h00, 8'h18, 1'b1);
      send(2'd3, 8'd5);
      wait_until(a + 7);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk(busy == 0 && ready == 1 && pat == 8'h18, "abort_result",
          {busy, ready, pat}, 10'h118);
      repeat (12) @(negedge clk);
      // reset in the middle of a rotate
      a = cyc + 1;
      push(a + 4, 8'hFF, 8'h30, 8'h30, 1'b0);
      send(2'd3, 8'd3);
      wait_until(a + 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk(en == 0 && pat == 0 && ready == 0 && busy == 1, "mid_reset_state",
          {en, 7'd0, ready, 7'd0, busy, pat}, 32'h0000_0100);
      push(cyc + 1, 8'hFF, 8'h00, 8'h00, 1'b0);
      repeat (20) @(negedge clk);
      chk(busy == 0 && pat == 0, "after_mid_reset", {busy, pat}, 0);
      chk(q.size() == 0, "events_outstanding", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/led_bank_sequencer.md
Name: led_bank_sequencer

Overview:
- Sole writer for a bank of NUM_LEDS enable-flip-flop LED indicator cells. Each cell is a 2:1 mux, a D flip-flop and an LED/resistor, with per-cell enable and data inputs.
- Accepts commands over a valid/ready interface: write, set bits, clear bits, timed rotate. Converts each into one-cycle enable/data strobes to the bank.
- Keeps a shadow copy of the bank contents, because the bank cells have no reset and no readback. Runs an init clear after reset.

Parameters:
- NUM_LEDS, 8, number of LED cells driven; >= 2.
- PRESCALE, 4, clock cycles between rotate steps; >= 1.
- STEP_W, 8, width of the rotate step count; <= NUM_LEDS.

Ports:
- clk_i  input  1  single clock.
- rst_i  input  1  synchronous active-high reset.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  command ready.
- cmd_op_i  input  2  0=WRITE, 1=SET, 2=CLEAR, 3=ROTATE.
- cmd_data_i  input  NUM_LEDS  pattern or mask; ROTATE uses bits [STEP_W-1:0] as the step count S.
- abort_i  input  1  stop a running ROTATE.
- en_o  output  NUM_LEDS  per-cell enable to the bank.
- d_o  output  NUM_LEDS  per-cell data to the bank.
- pattern_o  output  NUM_LEDS  shadow of bank contents.
- busy_o  output  1  high when state != IDLE.
- done_o  output  1  one-cycle pulse when a ROTATE ends.

Behaviour:
- Single clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: state=INIT, en_o=0, d_o=0, pattern_o=0, cmd_ready_o=0, busy_o=1, done_o=0, step counter=0, prescale counter=0.
- All outputs are registered. en_o and d_o are nonzero only in a strobe cycle; d_o=0 whenever en_o=0.
- Pattern timing: pattern_o updates on the same edge that registers a strobe. The bank Q equals pattern_o one cycle after the strobe is visible.
- FSM states: INIT, IDLE, RUN.
- INIT: first cycle after rst_i low. At that edge, register en_o=all ones, d_o=0, pattern_o=0, then go to IDLE. The strobe is visible in the 2nd cycle after reset release.
- rst_i high in any state returns to INIT with reset values, including mid-ROTATE; any strobe in flight is dropped.
- IDLE: cmd_ready_o=1. A command is accepted on an edge where cmd_valid_i && cmd_ready_o.
  - WRITE: en_o=all ones, d_o=data, pattern_o=data.
  - SET: en_o=data, d_o=data, pattern_o|=data.
  - CLEAR: en_o=data, d_o=0, pattern_o&=~data.
  - Each strobe is visible the cycle after acceptance. Back-to-back accepts every cycle are allowed; each command sees the pattern_o produced by the previous one.
  - ROTATE with S=0: no strobe; done_o pulses next cycle; stay IDLE.
  - ROTATE with S>0: load step counter=S, prescale counter=PRESCALE-1, go to RUN.
- RUN: cmd_ready_o=0, busy_o=1.
  - Each edge with prescale counter != 0: decrement it.
  - Each edge with prescale counter == 0: register en_o=all ones, d_o=rotl(pattern_o,1) (bit N-1 wraps to bit 0), pattern_o=rotl(pattern_o,1). Decrement steps and reload prescale to PRESCALE-1.
  - After the S-th strobe is registered, go to IDLE. done_o is high in the same cycle that last strobe is visible.
  - Strobe n (1..S) is registered at acceptance edge + n*PRESCALE.
- abort_i is sampled only in RUN. On an edge with abort_i=1: go to IDLE, no strobe on that edge (abort beats a coincident step), done_o pulses next cycle. pattern_o keeps the last strobed value.
- abort_i in IDLE or INIT is ignored.
- cmd_valid_i is ignored while cmd_ready_o=0; commands are not queued.

Test Plan:
- Reset then idle: rst_i high 2 cycles, then low → cycle 1 after release: en_o=0, ready=0. Cycle 2: en_o=0xFF, d_o=0x00. Cycle 3: en_o=0, ready=1, pattern_o=0.
- Back-to-back commands: WRITE 0xA5, SET 0x0F, CLEAR 0x81 on consecutive cycles → strobes in order: en=FF d=A5; en=0F d=0F; en=81 d=00. Final pattern_o=0x2E.
- Rotate, PRESCALE=4: WRITE 0x81 then ROTATE S=3 → strobes exactly 4, 8 and 12 cycles after acceptance, with d_o=0x03, 0x06, 0x0C. done_o coincides with the 3rd strobe; busy_o=0 afterwards.
- ROTATE S=0 → no strobe, done_o one cycle, ready stays 1.
- Abort coinciding with a step: ROTATE S=5, assert abort_i on the edge of step 2 → only step 1 strobed, pattern_o=rotl(initial,1), done_o next cycle, IDLE.
- Reset mid-rotate: rst_i pulsed during RUN → no further rotate strobes, INIT clear strobe (en=FF, d=00) follows, pattern_o=0.
